// File: rtl/aes128_pkg.sv
// Shared types for packing 128-bit AES ciphertext blocks into 512-bit cache lines.
package aes128_pkg;
    localparam int AES_BLOCKS_PER_LINE = 4;

    typedef logic [127:0] t_aes_block;
    typedef logic [511:0] t_aes_line;

    typedef struct packed {
        t_aes_line  line;
        logic [2:0] nblocks;
    } t_line_entry;
endpackage

// File: rtl/aes128_line_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO survives only
// when a pop frees the slot in the same cycle, otherwise it is dropped.
module aes128_line_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          drop_o
);
    T              mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;

    // Head is masked while empty so the output reads zero rather than stale storage.
    assign data_o = empty_o ? T'('0) : mem[rd_q];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_q] <= data_i;
    end
endmodule

// File: rtl/aes128_line_packer.sv
// Packs four consecutive AES ciphertext blocks into one 512-bit line and buffers
// lines for a write path that may stall; the core itself cannot be stalled.
module aes128_line_packer
    import aes128_pkg::*;
#(
    parameter int  LINE_FIFO_DEPTH = 16,
    parameter int  AF_MARGIN       = 4,
    localparam int CW              = $clog2(LINE_FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [127:0]  data_in,
    input  logic          valid_in,
    input  logic          flush_in,
    output logic [511:0]  line_out,
    output logic [2:0]    line_nblocks_out,
    output logic          line_valid_out,
    input  logic          line_ready_in,
    output logic [CW-1:0] count_out,
    output logic          almost_full_out,
    output logic          empty_out,
    output logic          overflow_out
);
    typedef logic [AES_BLOCKS_PER_LINE-1:0][127:0] t_slots;

    t_slots      asm_q, asm_d, slots;
    logic [1:0]  idx_q, idx_d;
    logic        push, drop, full, overflow_q;
    t_line_entry push_entry, head;

    always_comb begin
        asm_d      = asm_q;
        idx_d      = idx_q;
        slots      = asm_q;
        push       = 1'b0;
        push_entry = '0;
        if (valid_in) begin
            slots[idx_q] = data_in;
            if (idx_q == 2'd3 || flush_in) begin
                push               = 1'b1;
                push_entry.line    = t_aes_line'(slots);
                push_entry.nblocks = {1'b0, idx_q} + 3'd1;
                asm_d              = '0;
                idx_d              = '0;
            end else begin
                asm_d = slots;
                idx_d = idx_q + 2'd1;
            end
        end else if (flush_in && idx_q != 2'd0) begin
            // Slots at and above idx are already zero since the register clears on every push.
            push               = 1'b1;
            push_entry.line    = t_aes_line'(asm_q);
            push_entry.nblocks = {1'b0, idx_q};
            asm_d              = '0;
            idx_d              = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q      <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_q | drop;
        end
    end

    aes128_line_fifo #(
        .DEPTH (LINE_FIFO_DEPTH),
        .T     (t_line_entry)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (line_ready_in),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty_out),
        .count_o (count_out),
        .drop_o  (drop)
    );

    assign line_out         = head.line;
    assign line_nblocks_out = head.nblocks;
    assign line_valid_out   = !empty_out;
    assign almost_full_out  = (count_out >= CW'(LINE_FIFO_DEPTH - AF_MARGIN));
    assign overflow_out     = overflow_q;
endmodule

// File: tb/tb_aes128_line_packer.sv
// Randomized and directed bench for the AES line packer against a queue-based reference model.
module tb_aes128_line_packer;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] data_in;
    logic         valid_in, flush_in, line_ready_in;
    logic [511:0] line_out;
    logic [2:0]   line_nblocks_out;
    logic         line_valid_out;
    logic [4:0]   count_out;
    logic         almost_full_out, empty_out, overflow_out;

    aes128_line_packer #(.LINE_FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .flush_in         (flush_in),
        .line_out         (line_out),
        .line_nblocks_out (line_nblocks_out),
        .line_valid_out   (line_valid_out),
        .line_ready_in    (line_ready_in),
        .count_out        (count_out),
        .almost_full_out  (almost_full_out),
        .empty_out        (empty_out),
        .overflow_out     (overflow_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending blocks of the current line and a queue of finished lines.
    typedef struct {
        logic [511:0] line;
        int           nb;
    } mline_t;

    logic [127:0] part[$];
    mline_t       mq[$];
    bit           movf;

    task automatic model_reset();
        part.delete();
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic model_step();
        mline_t e;
        bit     do_push = 1'b0;
        if (valid_in) part.push_back(data_in);
        if (part.size() == 4 || (flush_in && part.size() > 0)) begin
            e.line = '0;
            foreach (part[k]) e.line[128*k +: 128] = part[k];
            e.nb = part.size();
            part.delete();
            do_push = 1'b1;
        end
        if (line_ready_in && mq.size() > 0) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else movf = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("valid", line_valid_out, mq.size() > 0);
        chk("count", count_out, mq.size());
        chk("empty", empty_out, mq.size() == 0);
        chk("afull", almost_full_out, mq.size() >= DEPTH - AFM);
        chk("ovf", overflow_out, movf);
        if (mq.size() > 0) begin
            chk("line", line_out, mq[0].line);
            chk("nblk", line_nblocks_out, mq[0].nb);
        end else begin
            chk("line_idle", line_out, '0);
            chk("nblk_idle", line_nblocks_out, '0);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input bit f, input bit r, input logic [127:0] d);
        valid_in      = v;
        flush_in      = f;
        line_ready_in = r;
        data_in       = d;
        cyc();
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, r, '0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, line_valid_out, 1'b0);
        chk({tag, "_empty"}, empty_out, 1'b1);
        chk({tag, "_count"}, count_out, 0);
        chk({tag, "_afull"}, almost_full_out, 1'b0);
        chk({tag, "_ovf"}, overflow_out, 1'b0);
        chk({tag, "_line"}, line_out, '0);
        chk({tag, "_nblk"}, line_nblocks_out, '0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b0;
        valid_in = 1'b0; flush_in = 1'b0; line_ready_in = 1'b0; data_in = '0;
        model_reset();
        #3;
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // Full line, valid the cycle after the 4th block
        drive(1, 0, 1, 128'h1);
        drive(1, 0, 1, 128'h2);
        drive(1, 0, 1, 128'h3);
        chk("full_not_yet", line_valid_out, 1'b0);
        drive(1, 0, 1, 128'h4);
        chk("full_valid", line_valid_out, 1'b1);
        chk("full_lo", line_out[127:0], 128'h1);
        chk("full_hi", line_out[511:384], 128'h4);
        chk("full_nb", line_nblocks_out, 3'd4);
        idle(1, 2);

        // Partial flush of two blocks
        drive(1, 0, 0, 128'hA1);
        drive(1, 0, 0, 128'hA2);
        drive(0, 1, 0, '0);
        chk("pf_nb", line_nblocks_out, 3'd2);
        chk("pf_upper", line_out[511:256], '0);
        idle(1, 2);

        // Flush with nothing pending is a no-op
        drive(0, 1, 1, '0);
        chk("pf_noop", line_valid_out, 1'b0);

        // Flush coincident with the 3rd block
        drive(1, 0, 0, 128'hB1);
        drive(1, 0, 0, 128'hB2);
        drive(1, 1, 0, 128'hB3);
        chk("pf3_nb", line_nblocks_out, 3'd3);
        chk("pf3_blk2", line_out[383:256], 128'hB3);
        idle(1, 2);

        // Backpressure: fill to 16 lines, then complete a line with a pop in the same cycle
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, rnd128());
            if (i == 43) chk("bp_af_lo", almost_full_out, 1'b0);
            if (i == 47) chk("bp_af_hi", almost_full_out, 1'b1);
        end
        chk("bp_count16", count_out, 16);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, rnd128());
        drive(1, 0, 1, rnd128());
        chk("simpop_count", count_out, 16);
        chk("simpop_ovf", overflow_out, 1'b0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, rnd128());
        chk("drop_ovf", overflow_out, 1'b1);
        chk("drop_count", count_out, 16);
        idle(1, 18);

        // Reset mid-operation: 3 lines buffered plus a partial line
        for (int i = 0; i < 14; i++) drive(1, 0, 0, rnd128());
        chk("mid_count3", count_out, 3);
        valid_in = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 128'hC0 + 128'(i));
        chk("post_rst_count", count_out, 1);
        chk("post_rst_nb", line_nblocks_out, 3'd4);
        chk("post_rst_lo", line_out[127:0], 128'hC0);
        idle(1, 2);

        // Randomized traffic with varying backpressure
        for (int ph = 0; ph < 12; ph++) begin
            int rp = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                drive(($urandom % 4) != 0, ($urandom % 8) == 0,
                      ($urandom % 4) < rp, rnd128());
            end
        end
        idle(1, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
